mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_if_pkg.sv | 20 ++
 rtl/mem_array.sv | 24 ++
 rtl/mem_responder.sv | 135 +++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared processor/memory interface definitions: bus widths, request codes
// and the captured-request payload.
package mem_if_pkg;

  localparam int unsigned WORDWIDTH    = 16;
  localparam int unsigned ADDRWIDTH    = 16;
  localparam int unsigned IOSTATEWIDTH = 2;

  localparam logic [IOSTATEWIDTH-1:0] IDLE = IOSTATEWIDTH'(0);
  localparam logic [IOSTATEWIDTH-1:0] RD   = IOSTATEWIDTH'(1);
  localparam logic [IOSTATEWIDTH-1:0] WT   = IOSTATEWIDTH'(2);
  localparam logic [IOSTATEWIDTH-1:0] ILL  = IOSTATEWIDTH'(3);

  typedef struct packed {
    logic [IOSTATEWIDTH-1:0] op;
    logic [ADDRWIDTH-1:0]    addr;
    logic [WORDWIDTH-1:0]    data;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
module mem_array
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [WORDWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [WORDWIDTH-1:0] rdata_o
);

  logic [WORDWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a processor request, waits LATENCY cycles,
// then acknowledges a read or commits a write until the processor returns to IDLE.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwToMem,
  input  logic [ADDRWIDTH-1:0]    addrToMem,
  input  logic [WORDWIDTH-1:0]    dataToMem,
  output logic                    rdEn,
  output logic                    wtEn,
  output logic [WORDWIDTH-1:0]    dataFromMem,
  output logic                    busy,
  output logic                    err,
  input  logic                    init_we,
  input  logic [ADDRWIDTH-1:0]    init_addr,
  input  logic [WORDWIDTH-1:0]    init_data
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTWIDTH = 4;
  localparam logic [ADDRWIDTH:0] DEPTH_EXT = (ADDRWIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  state_e               state_q;
  logic [CNTWIDTH-1:0]  cnt_q;
  mem_req_t             req_q;
  logic                 rd_en_q;
  logic                 wt_en_q;
  logic [WORDWIDTH-1:0] data_q;
  logic                 busy_q;
  logic                 err_q;

  logic                 in_range_c;
  logic                 init_in_range_c;
  logic                 ack_entry_c;
  logic                 fsm_we_c;
  logic                 bd_we_c;
  logic                 arr_we_c;
  logic [AW-1:0]        arr_waddr_c;
  logic [WORDWIDTH-1:0] arr_wdata_c;
  logic [WORDWIDTH-1:0] arr_rdata_c;

  assign in_range_c      = {1'b0, req_q.addr} < DEPTH_EXT;
  assign init_in_range_c = {1'b0, init_addr} < DEPTH_EXT;

  // The edge that enters ACK is the edge that performs the memory access.
  assign ack_entry_c = (state_q == ST_WAIT) && (rwToMem != IDLE) && (cnt_q == '0);

  // Reset must suppress a commit that would otherwise land on the same edge.
  assign fsm_we_c = !reset && ack_entry_c && (req_q.op == WT) && in_range_c;
  assign bd_we_c  = !reset && (state_q == ST_IDLE) && (rwToMem == IDLE) &&
                    init_we && init_in_range_c;

  assign arr_we_c    = fsm_we_c || bd_we_c;
  assign arr_waddr_c = fsm_we_c ? req_q.addr[AW-1:0] : init_addr[AW-1:0];
  assign arr_wdata_c = fsm_we_c ? req_q.data : init_data;

  mem_array #(.DEPTH(DEPTH)) u_mem_array (
    .clk     (clk),
    .we_i    (arr_we_c),
    .waddr_i (arr_waddr_c),
    .wdata_i (arr_wdata_c),
    .raddr_i (req_q.addr[AW-1:0]),
    .rdata_o (arr_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rd_en_q <= 1'b0;
      wt_en_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((rwToMem == RD) || (rwToMem == WT)) begin
            req_q   <= '{op: rwToMem, addr: addrToMem, data: dataToMem};
            cnt_q   <= CNTWIDTH'(LATENCY);
            state_q <= ST_WAIT;
            busy_q  <= 1'b1;
          end else if (rwToMem == ILL) begin
            err_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (rwToMem == IDLE) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= ST_ACK;
            if (req_q.op == RD) begin
              rd_en_q <= 1'b1;
              data_q  <= in_range_c ? arr_rdata_c : '0;
            end else begin
              wt_en_q <= 1'b1;
            end
            if (!in_range_c) err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNTWIDTH'(1);
          end
        end
        ST_ACK: begin
          if (rwToMem == IDLE) begin
            state_q <= ST_IDLE;
            rd_en_q <= 1'b0;
            wt_en_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdEn        = rd_en_q;
  assign wtEn        = wt_en_q;
  assign dataFromMem = data_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 and a LATENCY=0 instance share one
// stimulus stream and are compared against a transaction-level memory model.
module tb_mem_responder;
  import mem_if_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [IOSTATEWIDTH-1:0] rwToMem;
  logic [ADDRWIDTH-1:0]    addrToMem;
  logic [WORDWIDTH-1:0]    dataToMem;
  logic                    init_we;
  logic [ADDRWIDTH-1:0]    init_addr;
  logic [WORDWIDTH-1:0]    init_data;

  logic                 rd2, wt2, busy2, err2;
  logic [WORDWIDTH-1:0] dout2;
  logic                 rd0, wt0, busy0, err0;
  logic [WORDWIDTH-1:0] dout0;

  int total = 0;
  int bad   = 0;

  logic [WORDWIDTH-1:0] mem_m [DEPTH];
  logic                 err_m;
  logic [WORDWIDTH-1:0] last_rd;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .rwToMem(rwToMem), .addrToMem(addrToMem),
    .dataToMem(dataToMem), .rdEn(rd2), .wtEn(wt2), .dataFromMem(dout2),
    .busy(busy2), .err(err2), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .rwToMem(rwToMem), .addrToMem(addrToMem),
    .dataToMem(dataToMem), .rdEn(rd0), .wtEn(wt0), .dataFromMem(dout0),
    .busy(busy0), .err(err0), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both instances idle: no acknowledge, not busy, read data holding.
  task automatic check_idle(input string tag);
    check({tag, "_rd2"}, 32'(rd2), 0);
    check({tag, "_wt2"}, 32'(wt2), 0);
    check({tag, "_busy2"}, 32'(busy2), 0);
    check({tag, "_err2"}, 32'(err2), 32'(err_m));
    check({tag, "_dout2"}, 32'(dout2), 32'(last_rd));
    check({tag, "_rd0"}, 32'(rd0), 0);
    check({tag, "_wt0"}, 32'(wt0), 0);
    check({tag, "_busy0"}, 32'(busy0), 0);
    check({tag, "_err0"}, 32'(err0), 32'(err_m));
    check({tag, "_dout0"}, 32'(dout0), 32'(last_rd));
  endtask

  // Full transaction; inputs are scrambled after capture and the backdoor is
  // poked while busy, both of which must have no effect.
  task automatic do_req(input string tag, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] d);
    logic                 inr;
    logic [WORDWIDTH-1:0] exp_rd;
    logic                 ack2, ack0;
    inr    = (32'(a) < DEPTH);
    exp_rd = (op == RD) ? (inr ? mem_m[a[7:0]] : 16'h0000) : last_rd;
    rwToMem = op; addrToMem = a; dataToMem = d;
    tick();
    addrToMem = 16'($urandom);
    dataToMem = 16'($urandom);
    rwToMem   = 2'($urandom_range(1, 3));
    init_we   = 1'b1;
    init_addr = 16'($urandom_range(0, DEPTH - 1));
    init_data = 16'($urandom);
    for (int k = 1; k <= 4; k++) begin
      tick();
      ack2 = (k >= 3);
      ack0 = (k >= 1);
      check({tag, "_rd2"}, 32'(rd2), 32'(ack2 && op == RD));
      check({tag, "_wt2"}, 32'(wt2), 32'(ack2 && op == WT));
      check({tag, "_dout2"}, 32'(dout2), 32'((ack2 && op == RD) ? exp_rd : last_rd));
      check({tag, "_rd0"}, 32'(rd0), 32'(ack0 && op == RD));
      check({tag, "_wt0"}, 32'(wt0), 32'(ack0 && op == WT));
      check({tag, "_dout0"}, 32'(dout0), 32'((ack0 && op == RD) ? exp_rd : last_rd));
    end
    check({tag, "_busy2"}, 32'(busy2), 1);
    check({tag, "_busy0"}, 32'(busy0), 1);
    check({tag, "_err2"}, 32'(err2), 32'(err_m || !inr));
    check({tag, "_err0"}, 32'(err0), 32'(err_m || !inr));
    if (op == WT && inr) mem_m[a[7:0]] = d;
    if (!inr) err_m = 1'b1;
    if (op == RD) last_rd = exp_rd;
    rwToMem = IDLE;
    tick();
    init_we = 1'b0;
    check_idle({tag, "_rel"});
  endtask

  task automatic do_abort(input string tag, input logic [15:0] a, input logic [15:0] d);
    rwToMem = WT; addrToMem = a; dataToMem = d;
    tick();
    rwToMem = IDLE;
    tick();
    check_idle({tag, "_a1"});
    tick();
    check_idle({tag, "_a2"});
  endtask

  task automatic rand_req(input string tag, input int oor_pct);
    logic [1:0]  op;
    logic [15:0] a;
    op = ($urandom_range(0, 1) == 0) ? RD : WT;
    if ($urandom_range(0, 99) < oor_pct) a = 16'($urandom_range(DEPTH, 65535));
    else                                  a = 16'($urandom_range(0, DEPTH - 1));
    do_req(tag, op, a, 16'($urandom));
  endtask

  initial begin
    reset = 1'b1; rwToMem = IDLE; addrToMem = '0; dataToMem = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    err_m = 1'b0; last_rd = '0;
    tick(); tick();
    reset = 1'b0;
    check_idle("reset");

    for (int i = 0; i < int'(DEPTH); i++) begin
      init_we   = 1'b1;
      init_addr = 16'(i);
      init_data = (i == 5) ? 16'h1234 : (i == 30) ? 16'h0030 : 16'($urandom);
      mem_m[i]  = init_data;
      tick();
    end
    init_we = 1'b0;

    do_req("rd5", RD, 16'd5, 16'h0);
    do_req("wt7", WT, 16'd7, 16'hBEEF);
    do_req("rd7", RD, 16'd7, 16'h0);

    init_we = 1'b1; init_addr = 16'd9; init_data = 16'hA5A5; mem_m[9] = 16'hA5A5;
    tick();
    init_we = 1'b0;
    do_req("rd9", RD, 16'd9, 16'h0);

    do_abort("abort20", 16'd20, 16'hCAFE);
    do_req("rd20", RD, 16'd20, 16'h0);

    for (int n = 0; n < 30; n++) rand_req("rnd_a", 0);

    do_req("rd300", RD, 16'd300, 16'h0);
    do_req("wt300", WT, 16'd300, 16'h5555);
    do_req("rd44", RD, 16'd44, 16'h0);

    rwToMem = ILL;
    tick();
    check("ill_err2", 32'(err2), 1);
    check("ill_err0", 32'(err0), 1);
    check("ill_busy2", 32'(busy2), 0);
    check("ill_busy0", 32'(busy0), 0);
    err_m = 1'b1;
    rwToMem = IDLE;
    tick();

    rwToMem = WT; addrToMem = 16'd30; dataToMem = 16'hDEAD;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; rwToMem = IDLE;
    err_m = 1'b0; last_rd = '0;
    check_idle("rst_wait");
    do_req("rd30", RD, 16'd30, 16'h0);

    for (int n = 0; n < 20; n++) rand_req("rnd_b", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
